ps2_key_ctrl: RTL and testbench

//  Controller sequencing the ps2_keyboard receiver FIFO: pops bytes via the nextdata_n handshake,

---
 rtl/ps2_key_ctrl_if.sv | 30 +++
 rtl/ps2_key_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_ctrl_if.sv
// Key event stream between ps2_key_ctrl and its consumer.
//   evt_valid  : event FIFO holds at least one entry
//   evt_code   : scan code of the head event (0 when empty)
//   evt_ext    : head event carried an E0 prefix
//   evt_break  : head event is a key release (F0 prefix)
//   evt_ready  : consumer takes the head event when evt_valid is also high
// The master modport belongs to the controller, the slave modport to the consumer.
interface ps2_key_ctrl_if;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_ready;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_ext,
        output evt_break,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_ext,
        input  evt_break,
        output evt_ready
    );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receiver sequencer.
// Pops bytes from the ps2_keyboard receiver FIFO through the nextdata_n
// handshake, folds E0/F0 prefixes into key events, queues the events in a
// small FIFO, tracks the key currently held and counts distinct presses.
// Ports:
//   clk, reset           : system clock, synchronous active-high reset
//   ready/data/overflow  : receiver status, head byte and overflow flag
//   nextdata_n           : active-low, one-cycle pop strobe to the receiver
//   evt                  : event stream (master side of ps2_key_ctrl_if)
//   held_valid/held_code : key currently held down (extension bit not kept)
//   press_cnt            : number of distinct presses, wraps
//   err_ovf/err_code     : sticky receiver-overflow and bad-byte flags
//   clr_err              : clears both sticky flags
module ps2_key_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    input  logic [7:0]       data,
    input  logic             overflow,
    output logic             nextdata_n,
    ps2_key_ctrl_if.master   evt,
    output logic             held_valid,
    output logic [7:0]       held_code,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err_ovf,
    output logic             err_code,
    input  logic             clr_err
);
    localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACK, GAP} state_t;

    state_t             state_q, state_d;
    logic [7:0]         byte_q, byte_d;
    logic               ext_pend_q, ext_pend_d;
    logic               brk_pend_q, brk_pend_d;
    logic               nextdata_n_q, nextdata_n_d;
    logic               held_valid_q, held_valid_d;
    logic [7:0]         held_code_q, held_code_d;
    logic [CNT_W-1:0]   press_cnt_q, press_cnt_d;
    logic               err_ovf_q, err_ovf_d;
    logic               err_code_q, err_code_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [9:0]         mem_q [DEPTH];

    logic               push;
    logic               pop;
    logic               bad_byte;
    logic               fifo_nonempty;
    logic [9:0]         push_word;
    logic [9:0]         head_word;

    assign fifo_nonempty = (count_q != '0);
    assign head_word     = mem_q[rd_ptr_q];
    assign pop           = fifo_nonempty && evt.evt_ready;

    // FIFO entries are {code, ext, break}; outputs read as zero when empty.
    assign evt.evt_valid = fifo_nonempty;
    assign evt.evt_code  = fifo_nonempty ? head_word[9:2] : 8'h00;
    assign evt.evt_ext   = fifo_nonempty && head_word[1];
    assign evt.evt_break = fifo_nonempty && head_word[0];

    assign nextdata_n = nextdata_n_q;
    assign held_valid = held_valid_q;
    assign held_code  = held_code_q;
    assign press_cnt  = press_cnt_q;
    assign err_ovf    = err_ovf_q;
    assign err_code   = err_code_q;

    // Pop sequencing and byte parsing. A byte is only taken from the
    // receiver when the event FIFO has room, so a push in ACK can never
    // overflow: pops in the meantime only free space.
    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        held_valid_d = held_valid_q;
        held_code_d  = held_code_q;
        press_cnt_d  = press_cnt_q;
        push         = 1'b0;
        bad_byte     = 1'b0;
        push_word    = {byte_q, ext_pend_q, brk_pend_q};

        case (state_q)
            IDLE: begin
                if (ready && (count_q < FULL_CNT)) begin
                    byte_d  = data;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = GAP;
                case (byte_q)
                    8'hE0: ext_pend_d = 1'b1;
                    8'hF0: brk_pend_d = 1'b1;
                    8'h00, 8'hFF: begin
                        bad_byte   = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                    default: begin
                        push       = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                        // A make of the key already held is typematic repeat
                        // and must not count as a new press.
                        if (!brk_pend_q) begin
                            if (!(held_valid_q && (held_code_q == byte_q))) begin
                                press_cnt_d  = press_cnt_q + CNT_W'(1);
                                held_code_d  = byte_q;
                                held_valid_d = 1'b1;
                            end
                        end else if (held_code_q == byte_q) begin
                            held_valid_d = 1'b0;
                        end
                    end
                endcase
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The strobe is registered, so it is low exactly while in ACK.
        nextdata_n_d = (state_d != ACK);

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        // Setting a sticky error wins over clearing it in the same cycle.
        err_ovf_d  = overflow ? 1'b1 : (clr_err ? 1'b0 : err_ovf_q);
        err_code_d = bad_byte ? 1'b1 : (clr_err ? 1'b0 : err_code_q);
    end

    // Reset drops any byte caught mid-ACK: no push and the strobe returns high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            byte_q       <= 8'h00;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            nextdata_n_q <= 1'b1;
            held_valid_q <= 1'b0;
            held_code_q  <= 8'h00;
            press_cnt_q  <= '0;
            err_ovf_q    <= 1'b0;
            err_code_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            nextdata_n_q <= nextdata_n_d;
            held_valid_q <= held_valid_d;
            held_code_q  <= held_code_d;
            press_cnt_q  <= press_cnt_d;
            err_ovf_q    <= err_ovf_d;
            err_code_q   <= err_code_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= push_word;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: a table of receiver bytes with the
// expected held/count/error state after each, a scoreboard of expected
// events checked as the consumer pops them, and hand-written sequences for
// backpressure, sticky errors, reset during ACK and counter wrap.
module tb_ps2_key_ctrl;
    logic       clk;
    logic       reset;
    logic       ready;
    logic [7:0] data;
    logic       overflow;
    logic       nextdata_n;
    logic       held_valid;
    logic [7:0] held_code;
    logic [7:0] press_cnt;
    logic       err_ovf;
    logic       err_code;
    logic       clr_err;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];

    typedef struct {
        logic [7:0] b;
        logic       push;
        logic       ext;
        logic       brk;
        logic       hv;
        logic [7:0] hc;
        logic [7:0] cnt;
        logic       ec;
    } vec_t;

    vec_t vecs[25];

    ps2_key_ctrl_if evt_if();

    ps2_key_ctrl #(.DEPTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .ready      (ready),
        .data       (data),
        .overflow   (overflow),
        .nextdata_n (nextdata_n),
        .evt        (evt_if),
        .held_valid (held_valid),
        .held_code  (held_code),
        .press_cnt  (press_cnt),
        .err_ovf    (err_ovf),
        .err_code   (err_code),
        .clr_err    (clr_err)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the DUT wedges the stimulus somewhere unexpected.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectEvent(input logic [7:0] code, input logic ext, input logic brk);
        exp_q.push_back({code, ext, brk});
    endtask

    // Presents one byte as the receiver would, waits for the pop strobe,
    // withdraws ready, and checks the strobe lasted a single cycle.
    task automatic applyStimulus(input logic [7:0] b);
        int budget;
        budget = 0;
        @(posedge clk); #1;
        ready = 1'b1;
        data  = b;
        @(negedge clk);
        while (nextdata_n && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (nextdata_n) begin
            checks++;
            errors++;
            $display("[TB] FAIL pop_timeout: byte 0x%0h never popped, required nextdata_n low", b);
            ready = 1'b0;
            return;
        end
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("pop_width_%0h", b), 32'(nextdata_n), 32'd1);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Scoreboard: every event the consumer takes must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && evt_if.evt_valid && evt_if.evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: actual code 0x%0h ext %0b brk %0b, required none",
                         evt_if.evt_code, evt_if.evt_ext, evt_if.evt_break);
            end else begin
                checkOutput("event", 32'({evt_if.evt_code, evt_if.evt_ext, evt_if.evt_break}),
                            32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int low_seen;
        int budget;

        //          byte   push ext brk hv  hc     cnt    ec
        vecs[0]  = '{8'h1C, 1, 0, 0, 1, 8'h1C, 8'd1, 0};
        vecs[1]  = '{8'hF0, 0, 0, 0, 1, 8'h1C, 8'd1, 0};
        vecs[2]  = '{8'h1C, 1, 0, 1, 0, 8'h1C, 8'd1, 0};
        vecs[3]  = '{8'hE0, 0, 0, 0, 0, 8'h1C, 8'd1, 0};
        vecs[4]  = '{8'h75, 1, 1, 0, 1, 8'h75, 8'd2, 0};
        vecs[5]  = '{8'hE0, 0, 0, 0, 1, 8'h75, 8'd2, 0};
        vecs[6]  = '{8'hF0, 0, 0, 0, 1, 8'h75, 8'd2, 0};
        vecs[7]  = '{8'h75, 1, 1, 1, 0, 8'h75, 8'd2, 0};
        vecs[8]  = '{8'h1C, 1, 0, 0, 1, 8'h1C, 8'd3, 0};
        vecs[9]  = '{8'h1C, 1, 0, 0, 1, 8'h1C, 8'd3, 0};
        vecs[10] = '{8'h1C, 1, 0, 0, 1, 8'h1C, 8'd3, 0};
        vecs[11] = '{8'h1C, 1, 0, 0, 1, 8'h1C, 8'd3, 0};
        vecs[12] = '{8'hF0, 0, 0, 0, 1, 8'h1C, 8'd3, 0};
        vecs[13] = '{8'h1C, 1, 0, 1, 0, 8'h1C, 8'd3, 0};
        vecs[14] = '{8'hE0, 0, 0, 0, 0, 8'h1C, 8'd3, 0};
        vecs[15] = '{8'h00, 0, 0, 0, 0, 8'h1C, 8'd3, 1};
        vecs[16] = '{8'h1C, 1, 0, 0, 1, 8'h1C, 8'd4, 1};
        vecs[17] = '{8'hF0, 0, 0, 0, 1, 8'h1C, 8'd4, 1};
        vecs[18] = '{8'h1C, 1, 0, 1, 0, 8'h1C, 8'd4, 1};
        vecs[19] = '{8'h2A, 1, 0, 0, 1, 8'h2A, 8'd5, 1};
        vecs[20] = '{8'hF0, 0, 0, 0, 1, 8'h2A, 8'd5, 1};
        vecs[21] = '{8'h1C, 1, 0, 1, 1, 8'h2A, 8'd5, 1};
        vecs[22] = '{8'hF0, 0, 0, 0, 1, 8'h2A, 8'd5, 1};
        vecs[23] = '{8'h2A, 1, 0, 1, 0, 8'h2A, 8'd5, 1};
        vecs[24] = '{8'hFF, 0, 0, 0, 0, 8'h2A, 8'd5, 1};

        reset             = 1'b1;
        ready             = 1'b0;
        data              = 8'h00;
        overflow          = 1'b0;
        clr_err           = 1'b0;
        evt_if.evt_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        checkOutput("rst_nextdata_n", 32'(nextdata_n), 32'd1);
        checkOutput("rst_evt_valid", 32'(evt_if.evt_valid), 32'd0);
        checkOutput("rst_evt_fields", 32'({evt_if.evt_code, evt_if.evt_ext, evt_if.evt_break}), 32'd0);
        checkOutput("rst_held", 32'({held_valid, held_code}), 32'd0);
        checkOutput("rst_press_cnt", 32'(press_cnt), 32'd0);
        checkOutput("rst_errors", 32'({err_ovf, err_code}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Table-driven byte stream with a draining consumer
        for (int i = 0; i < 25; i++) begin
            if (vecs[i].push) expectEvent(vecs[i].b, vecs[i].ext, vecs[i].brk);
            applyStimulus(vecs[i].b);
            checkOutput($sformatf("v%0d_held_valid", i), 32'(held_valid), 32'(vecs[i].hv));
            checkOutput($sformatf("v%0d_held_code", i), 32'(held_code), 32'(vecs[i].hc));
            checkOutput($sformatf("v%0d_press_cnt", i), 32'(press_cnt), 32'(vecs[i].cnt));
            checkOutput($sformatf("v%0d_err_code", i), 32'(err_code), 32'(vecs[i].ec));
        end
        repeat (2) @(negedge clk);
        checkOutput("table_drained", 32'(exp_q.size()), 32'd0);

        // Sticky error flags
        @(posedge clk); #1; clr_err = 1'b1;
        @(posedge clk); #1; clr_err = 1'b0;
        @(negedge clk);
        checkOutput("clr_err_code", 32'(err_code), 32'd0);
        @(posedge clk); #1; overflow = 1'b1;
        @(posedge clk); #1; overflow = 1'b0;
        @(negedge clk);
        checkOutput("ovf_set", 32'(err_ovf), 32'd1);
        @(posedge clk); #1; overflow = 1'b1; clr_err = 1'b1;
        @(posedge clk); #1; overflow = 1'b0; clr_err = 1'b0;
        @(negedge clk);
        checkOutput("ovf_set_beats_clr", 32'(err_ovf), 32'd1);
        @(posedge clk); #1; clr_err = 1'b1;
        @(posedge clk); #1; clr_err = 1'b0;
        @(negedge clk);
        checkOutput("ovf_cleared", 32'(err_ovf), 32'd0);

        // Reset arriving while a byte is in ACK
        @(posedge clk); #1;
        ready = 1'b1;
        data  = 8'h33;
        budget = 0;
        @(negedge clk);
        while (nextdata_n && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("ack_reached", 32'(nextdata_n), 32'd0);
        reset = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        checkOutput("rst_ack_nextdata_n", 32'(nextdata_n), 32'd1);
        checkOutput("rst_ack_evt_valid", 32'(evt_if.evt_valid), 32'd0);
        checkOutput("rst_ack_press_cnt", 32'(press_cnt), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        expectEvent(8'h44, 1'b0, 1'b0);
        applyStimulus(8'h44);
        checkOutput("post_rst_press_cnt", 32'(press_cnt), 32'd1);
        checkOutput("post_rst_held", 32'({held_valid, held_code}), 32'h144);

        // Backpressure: eight events fill the FIFO, the ninth byte must wait
        @(posedge clk); #1;
        evt_if.evt_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expectEvent(8'h21 + 8'(i), 1'b0, 1'b0);
            applyStimulus(8'h21 + 8'(i));
        end
        checkOutput("full_evt_valid", 32'(evt_if.evt_valid), 32'd1);
        checkOutput("full_head_code", 32'(evt_if.evt_code), 32'h21);
        @(posedge clk); #1;
        ready = 1'b1;
        data  = 8'h29;
        low_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (!nextdata_n) low_seen++;
        end
        checkOutput("full_no_pop", 32'(low_seen), 32'd0);
        @(posedge clk); #1;
        evt_if.evt_ready = 1'b1;
        expectEvent(8'h29, 1'b0, 1'b0);
        applyStimulus(8'h29);
        expectEvent(8'h2A, 1'b0, 1'b0);
        applyStimulus(8'h2A);
        repeat (12) @(negedge clk);
        checkOutput("backpressure_drained", 32'(exp_q.size()), 32'd0);

        // 256 distinct presses wrap the 8-bit counter back to zero
        doReset();
        for (int i = 0; i < 256; i++) begin
            expectEvent((i % 2 == 1) ? 8'h11 : 8'h10, 1'b0, 1'b0);
            applyStimulus((i % 2 == 1) ? 8'h11 : 8'h10);
            if (i == 254) checkOutput("press_cnt_255", 32'(press_cnt), 32'd255);
        end
        checkOutput("press_cnt_wrap", 32'(press_cnt), 32'd0);
        checkOutput("wrap_held", 32'({held_valid, held_code}), 32'h111);
        repeat (4) @(negedge clk);
        checkOutput("final_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
